fc_layer_ctrl: RTL and testbench

Sequencer for one fully connected layer. Steps the input-neuron and weight read addresses, gates the accumulator, then drives the 5-phase write-back sequence (`count_sload`, `count_out`, `enable`) consumed by the FC result writer for each of OUTNEURON/PO output groups. Sits between the layer-level start/done handshake and the FC datapath (MAC array, result writer, output-neuron RAM).

---
 rtl/fc_param_pkg.sv | 36 +++
 rtl/fc_rd_delay.sv | 34 +++
 rtl/fc_layer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fc_layer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_param_pkg.sv
// -----------------------------------------------------------------------------
// fc_param_pkg
// Shared constants and types for the fully connected layer controller.
//   - Layer geometry: INNEURON, OUTNEURON, PO, GROUPS, RD_LAT
//   - Width constants for the controller outputs
//   - fc_ctrl_state_t: controller FSM state encoding
//   - SLOAD_*: write-back phase numbers seen by the FC result writer
// -----------------------------------------------------------------------------
package fc_param_pkg;

  localparam int unsigned INNEURON  = 64;
  localparam int unsigned OUTNEURON = 40;
  localparam int unsigned PO        = 4;
  localparam int unsigned GROUPS    = OUTNEURON / PO;
  localparam int unsigned RD_LAT    = 1;

  localparam int unsigned FC_COUNT_SLOAD_BITWIDTH      = 3;
  localparam int unsigned FC_COUNT_OUT_NEURON_BITWIDTH = 5;
  localparam int unsigned IN_ADDR_WIDTH                = 6;
  localparam int unsigned W_ADDR_WIDTH                 = 10;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFlush,
    StDrain,
    StDone
  } fc_ctrl_state_t;

  // Write-back phases: 1 advances the writer address, 2 captures the
  // accumulator, 3..5 assert the writer's write-enable.
  localparam int unsigned SLOAD_ADV     = 1;
  localparam int unsigned SLOAD_CAP     = 2;
  localparam int unsigned SLOAD_WR_LAST = 5;

endpackage

// File: rtl/fc_rd_delay.sv
// -----------------------------------------------------------------------------
// fc_rd_delay
// DEPTH-stage, 1-bit shift register with synchronous clear. Aligns the
// read-issue strobe with data returning from the neuron/weight RAMs.
//   i_clock : clock, rising edge
//   i_clear : synchronous clear of every stage (active high)
//   i_in    : strobe entering the delay line
//   o_out   : i_in delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module fc_rd_delay #(
  parameter int unsigned DEPTH = fc_param_pkg::RD_LAT
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_in,
  output logic o_out
);

  logic [DEPTH-1:0] r_shift;

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_shift <= '0;
    end else begin
      r_shift[0] <= i_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_shift[i] <= r_shift[i-1];
      end
    end
  end

  assign o_out = r_shift[DEPTH-1];

endmodule

// File: rtl/fc_layer_ctrl.sv
// -----------------------------------------------------------------------------
// fc_layer_ctrl
// Sequencer for one fully connected layer. For each of OUTNEURON/PO output
// groups it walks the input-neuron and weight read addresses, gates the MAC
// accumulators, waits for the last read to land, then runs the 5-phase
// write-back sequence consumed by the FC result writer.
//   i_clock         : clock, rising edge
//   i_reset         : synchronous reset, active high
//   i_start         : begin a layer pass (sampled only when idle)
//   i_hold          : stall input fetch (honoured only while accumulating)
//   o_in_addr       : input-neuron RAM read address
//   o_w_addr        : weight RAM read address = group*INNEURON + in_addr
//   o_acc_clear     : 1-cycle accumulator clear at the start of each group
//   o_acc_en        : accumulate the read data returning this cycle
//   o_enable        : result writer enable (write-back window)
//   o_count_sload   : write-back phase, 1..5 inside the window, else 0
//   o_count_out     : groups completed in this pass
//   o_busy          : high whenever a pass is in progress
//   o_done          : 1-cycle pulse at end of pass
// -----------------------------------------------------------------------------
module fc_layer_ctrl #(
  parameter int unsigned INNEURON                     = fc_param_pkg::INNEURON,
  parameter int unsigned OUTNEURON                    = fc_param_pkg::OUTNEURON,
  parameter int unsigned PO                           = fc_param_pkg::PO,
  parameter int unsigned RD_LAT                       = fc_param_pkg::RD_LAT,  // 1..4
  parameter int unsigned FC_COUNT_SLOAD_BITWIDTH      = fc_param_pkg::FC_COUNT_SLOAD_BITWIDTH,
  parameter int unsigned FC_COUNT_OUT_NEURON_BITWIDTH =
    fc_param_pkg::FC_COUNT_OUT_NEURON_BITWIDTH,
  parameter int unsigned IN_ADDR_WIDTH                = fc_param_pkg::IN_ADDR_WIDTH,
  parameter int unsigned W_ADDR_WIDTH                 = fc_param_pkg::W_ADDR_WIDTH
) (
  input  logic                                    i_clock,
  input  logic                                    i_reset,
  input  logic                                    i_start,
  input  logic                                    i_hold,
  output logic [IN_ADDR_WIDTH-1:0]                o_in_addr,
  output logic [W_ADDR_WIDTH-1:0]                 o_w_addr,
  output logic                                    o_acc_clear,
  output logic                                    o_acc_en,
  output logic                                    o_enable,
  output logic [FC_COUNT_SLOAD_BITWIDTH-1:0]      o_count_sload,
  output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] o_count_out,
  output logic                                    o_busy,
  output logic                                    o_done
);

  import fc_param_pkg::*;

  localparam int unsigned NUM_GROUPS = OUTNEURON / PO;
  localparam int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned FLUSH_W    = 3;
  localparam int unsigned SW         = FC_COUNT_SLOAD_BITWIDTH;
  localparam int unsigned CW         = FC_COUNT_OUT_NEURON_BITWIDTH;

  fc_ctrl_state_t         r_state;
  logic [GRP_W-1:0]       r_group;
  logic [FLUSH_W-1:0]     r_flush_cnt;
  logic [IN_ADDR_WIDTH-1:0] r_in_addr;
  logic [W_ADDR_WIDTH-1:0]  r_w_addr;
  logic                   r_acc_clear;
  logic                   r_enable;
  logic [SW-1:0]          r_count_sload;
  logic [CW-1:0]          r_count_out;
  logic                   r_busy;
  logic                   r_done;

  logic                     w_issue;
  logic                     w_last_addr;
  logic                     w_last_group;
  logic                     w_flush_end;
  logic                     w_drain_end;
  logic [IN_ADDR_WIDTH-1:0] w_in_addr_inc;
  logic [W_ADDR_WIDTH-1:0]  w_grp_base;
  logic [W_ADDR_WIDTH-1:0]  w_next_base;

  // A read is issued in every accumulate cycle that is not stalled.
  assign w_issue       = (r_state == StAccum) && !i_hold;
  assign w_last_addr   = (r_in_addr == IN_ADDR_WIDTH'(INNEURON - 1));
  assign w_last_group  = (r_group == GRP_W'(NUM_GROUPS - 1));
  assign w_flush_end   = (r_flush_cnt == FLUSH_W'(RD_LAT - 1));
  assign w_drain_end   = (r_count_sload == SW'(SLOAD_WR_LAST));
  assign w_in_addr_inc = r_in_addr + IN_ADDR_WIDTH'(1);
  assign w_grp_base    = W_ADDR_WIDTH'(r_group) * W_ADDR_WIDTH'(INNEURON);
  assign w_next_base   = w_grp_base + W_ADDR_WIDTH'(INNEURON);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_group       <= '0;
      r_flush_cnt   <= '0;
      r_in_addr     <= '0;
      r_w_addr      <= '0;
      r_acc_clear   <= 1'b0;
      r_enable      <= 1'b0;
      r_count_sload <= '0;
      r_count_out   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // Pulse outputs default low.
      r_acc_clear <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state     <= StAccum;
            r_group     <= '0;
            r_count_out <= '0;
            r_in_addr   <= '0;
            r_w_addr    <= '0;
            r_acc_clear <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        StAccum: begin
          if (!i_hold) begin
            if (w_last_addr) begin
              // Address stays parked on the last one; no wrap inside a group.
              r_state     <= StFlush;
              r_flush_cnt <= '0;
            end else begin
              r_in_addr <= w_in_addr_inc;
              r_w_addr  <= w_grp_base + W_ADDR_WIDTH'(w_in_addr_inc);
            end
          end
        end

        StFlush: begin
          // Wait until the final read has been accumulated before capture.
          if (w_flush_end) begin
            r_state       <= StDrain;
            r_count_out   <= r_count_out + CW'(1);
            r_count_sload <= SW'(SLOAD_ADV);
            r_enable      <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
          end
        end

        StDrain: begin
          if (w_drain_end) begin
            r_count_sload <= '0;
            r_enable      <= 1'b0;
            if (w_last_group) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StAccum;
              r_group     <= r_group + GRP_W'(1);
              r_in_addr   <= '0;
              r_w_addr    <= w_next_base;
              r_acc_clear <= 1'b1;
            end
          end else begin
            r_count_sload <= r_count_sload + SW'(1);
          end
        end

        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  fc_rd_delay #(
    .DEPTH (RD_LAT)
  ) u_rd_delay (
    .i_clock (i_clock),
    .i_clear (i_reset),
    .i_in    (w_issue),
    .o_out   (o_acc_en)
  );

  assign o_in_addr     = r_in_addr;
  assign o_w_addr      = r_w_addr;
  assign o_acc_clear   = r_acc_clear;
  assign o_enable      = r_enable;
  assign o_count_sload = r_count_sload;
  assign o_count_out   = r_count_out;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
module tb_fc_layer_ctrl;

  localparam int INNEURON = 64;
  localparam int GROUPS   = 10;
  localparam int NDRAIN   = 5;

  logic clk;
  logic sel;      // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
  logic rst0, rst1, start_v, hold_v;

  logic       start0, hold0, start1, hold1;
  logic [5:0] in_addr0, in_addr1;
  logic [9:0] w_addr0, w_addr1;
  logic       clr0, clr1, acc0, acc1, en0, en1, busy0, busy1, done0, done1;
  logic [2:0] sl0, sl1;
  logic [4:0] co0, co1;

  logic [5:0] m_in_addr;
  logic [9:0] m_w_addr;
  logic       m_clr, m_acc, m_en, m_busy, m_done;
  logic [2:0] m_sl;
  logic [4:0] m_co;

  int errors = 0;
  int checks = 0;

  assign start0 = !sel && start_v;
  assign hold0  = !sel && hold_v;
  assign start1 = sel && start_v;
  assign hold1  = sel && hold_v;

  assign m_in_addr = sel ? in_addr1 : in_addr0;
  assign m_w_addr  = sel ? w_addr1 : w_addr0;
  assign m_clr     = sel ? clr1 : clr0;
  assign m_acc     = sel ? acc1 : acc0;
  assign m_en      = sel ? en1 : en0;
  assign m_sl      = sel ? sl1 : sl0;
  assign m_co      = sel ? co1 : co0;
  assign m_busy    = sel ? busy1 : busy0;
  assign m_done    = sel ? done1 : done0;

  fc_layer_ctrl u_dut0 (
    .i_clock       (clk),
    .i_reset       (rst0),
    .i_start       (start0),
    .i_hold        (hold0),
    .o_in_addr     (in_addr0),
    .o_w_addr      (w_addr0),
    .o_acc_clear   (clr0),
    .o_acc_en      (acc0),
    .o_enable      (en0),
    .o_count_sload (sl0),
    .o_count_out   (co0),
    .o_busy        (busy0),
    .o_done        (done0)
  );

  fc_layer_ctrl #(
    .RD_LAT (3)
  ) u_dut1 (
    .i_clock       (clk),
    .i_reset       (rst1),
    .i_start       (start1),
    .i_hold        (hold1),
    .o_in_addr     (in_addr1),
    .o_w_addr      (w_addr1),
    .o_acc_clear   (clr1),
    .o_acc_en      (acc1),
    .o_enable      (en1),
    .o_count_sload (sl1),
    .o_count_out   (co1),
    .o_busy        (busy1),
    .o_done        (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [28:0] outs();
    return {m_in_addr, m_w_addr, m_clr, m_acc, m_en, m_sl, m_co, m_busy, m_done};
  endfunction

  task automatic check_vec(input string name, input logic [28:0] exp);
    logic [28:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulses start, then follows the pass cycle by cycle (cycle 1 = first
  // ACCUM cycle) until one cycle after done, or until limit expires.
  task automatic run_pass(input int rd, input int hold_waddr, input int hold_len,
                          input int sb_a, input int sb_b, input int limit,
                          output int done_cyc, output int n_acc, output int n_done,
                          output int first_acc, output int n_drain, output int seq_err,
                          output int trig_cnt, output int gap_err);
    int hold_left, trig_c, prev_sl;
    bit hold_used, prev_en;
    done_cyc = -1; n_acc = 0; n_done = 0; first_acc = -1; n_drain = 0;
    seq_err = 0; trig_cnt = 0; gap_err = 0;
    hold_left = 0; trig_c = -1000; prev_sl = 0; hold_used = 0; prev_en = 0;
    start_v = 1'b1;
    hold_v  = 1'b0;
    step();
    start_v = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (m_acc) begin
        n_acc++;
        if (first_acc < 0) first_acc = c;
      end
      if (m_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (m_en) begin
        if (m_sl == 3'd1) begin
          n_drain++;
          if (prev_en || int'(m_co) != n_drain) seq_err++;
        end else if (int'(m_sl) != prev_sl + 1 || int'(m_co) != n_drain) begin
          seq_err++;
        end
      end else begin
        if (m_sl != 3'd0) seq_err++;
        if (prev_en && prev_sl != NDRAIN) seq_err++;
      end
      prev_en = m_en;
      prev_sl = int'(m_sl);
      if (done_cyc < 0 && !m_busy) seq_err++;
      if (done_cyc >= 0 && c == done_cyc + 1 && m_busy) seq_err++;
      if (!hold_used && hold_len > 0 && int'(m_w_addr) == hold_waddr && m_busy && !m_en) begin
        hold_used = 1;
        hold_left = hold_len;
        trig_c    = c;
      end
      if (hold_used && int'(m_w_addr) == hold_waddr) trig_cnt++;
      if (c >= trig_c + rd && c < trig_c + rd + hold_len && m_acc) gap_err++;
      if (c == trig_c + rd + hold_len && !m_acc) gap_err++;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        start_v = 1'b0;
        hold_v  = 1'b0;
        break;
      end
      hold_v  = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      start_v = (c == sb_a || c == sb_b);
      step();
    end
    start_v = 1'b0;
    hold_v  = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       rst, start, hold;
    logic [5:0] e_in;
    logic [9:0] e_w;
    logic       e_clr, e_acc, e_en;
    logic [2:0] e_sl;
    logic [4:0] e_co;
    logic       e_busy, e_done;
  } vec_t;

  function automatic vec_t mk(input string n, input logic r, input logic s, input logic h,
                              input int ein, input int ew, input logic clr, input logic acc,
                              input logic busy);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.hold = h;
    v.e_in = 6'(ein); v.e_w = 10'(ew);
    v.e_clr = clr; v.e_acc = acc; v.e_en = 1'b0; v.e_sl = 3'd0; v.e_co = 5'd0;
    v.e_busy = busy; v.e_done = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t tbl[13];
    int dc, na, nd, fa, ndr, se, tc, ge;
    int found, cnt_done, cnt_busy;

    //         name             rst  st   hold in w  clr  acc  busy
    tbl[0]  = mk("reset",        1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk("idle",         0, 0, 0,  0, 0, 0, 0, 0);
    tbl[2]  = mk("start",        0, 1, 0,  0, 0, 1, 0, 1);
    tbl[3]  = mk("issue0",       0, 0, 0,  1, 1, 0, 1, 1);
    tbl[4]  = mk("hold_a",       0, 0, 1,  1, 1, 0, 0, 1);
    tbl[5]  = mk("hold_b",       0, 0, 1,  1, 1, 0, 0, 1);
    tbl[6]  = mk("resume",       0, 0, 0,  2, 2, 0, 1, 1);
    tbl[7]  = mk("start_busy",   0, 1, 0,  3, 3, 0, 1, 1);
    tbl[8]  = mk("reset_mid",    1, 0, 0,  0, 0, 0, 0, 0);
    tbl[9]  = mk("reset_start",  1, 1, 0,  0, 0, 0, 0, 0);
    tbl[10] = mk("idle2",        0, 0, 0,  0, 0, 0, 0, 0);
    tbl[11] = mk("restart",      0, 1, 0,  0, 0, 1, 0, 1);
    tbl[12] = mk("reset_again",  1, 0, 0,  0, 0, 0, 0, 0);

    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1; start_v = 1'b0; hold_v = 1'b0;

    for (int i = 0; i < 13; i++) begin
      rst0    = tbl[i].rst;
      start_v = tbl[i].start;
      hold_v  = tbl[i].hold;
      step();
      check_vec(tbl[i].name, {tbl[i].e_in, tbl[i].e_w, tbl[i].e_clr, tbl[i].e_acc,
                              tbl[i].e_en, tbl[i].e_sl, tbl[i].e_co, tbl[i].e_busy,
                              tbl[i].e_done});
    end
    rst0 = 1'b0; start_v = 1'b0; hold_v = 1'b0;
    step();

    // Nominal pass, RD_LAT=1.
    run_pass(1, -1, 0, -1, -1, 800, dc, na, nd, fa, ndr, se, tc, ge);
    check_int("nom_done_cycle", dc, GROUPS * (INNEURON + 1 + NDRAIN) + 1);
    check_int("nom_acc_en_count", na, INNEURON * GROUPS);
    check_int("nom_done_pulses", nd, 1);
    check_int("nom_first_acc_en", fa, 2);
    check_int("nom_drain_windows", ndr, GROUPS);
    check_int("nom_sequence_errs", se, 0);
    check_int("nom_count_out_hold", int'(m_co), GROUPS);
    check_int("nom_idle_busy", int'(m_busy), 0);

    // Hold for 3 cycles while in_addr shows 21 in group 0.
    run_pass(1, 21, 3, -1, -1, 800, dc, na, nd, fa, ndr, se, tc, ge);
    check_int("hold_done_cycle", dc, 704);
    check_int("hold_acc_en_count", na, INNEURON * GROUPS);
    check_int("hold_addr_frozen", tc, 4);
    check_int("hold_acc_en_gap", ge, 0);
    check_int("hold_sequence_errs", se + (ndr - GROUPS), 0);

    // Hold for 2 cycles on the last address of group 0.
    run_pass(1, 63, 2, -1, -1, 800, dc, na, nd, fa, ndr, se, tc, ge);
    check_int("hold_last_done_cycle", dc, 703);
    check_int("hold_last_acc_en", na, INNEURON * GROUPS);
    check_int("hold_last_drains", ndr, GROUPS);
    check_int("hold_last_seq_errs", se + ge, 0);

    // start pulses while busy are ignored.
    run_pass(1, -1, 0, 100, 400, 800, dc, na, nd, fa, ndr, se, tc, ge);
    check_int("busy_start_done_cycle", dc, 701);
    check_int("busy_start_done_pulses", nd, 1);
    check_int("busy_start_seq_errs", se, 0);
    step();
    check_int("busy_start_no_restart", int'(m_busy), 0);

    // Reset during DRAIN of group 4 at phase 3.
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    found = 0;
    for (int c = 0; c < 800; c++) begin
      if (m_en && m_sl == 3'd3 && m_co == 5'd5) begin
        found = 1;
        break;
      end
      step();
    end
    check_int("rst_drain_reached", found, 1);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    check_vec("rst_outputs_zero", 29'd0);
    cnt_done = 0; cnt_busy = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (m_done) cnt_done++;
      if (m_busy) cnt_busy++;
    end
    check_int("rst_no_done", cnt_done, 0);
    check_int("rst_stays_idle", cnt_busy, 0);
    run_pass(1, -1, 0, -1, -1, 800, dc, na, nd, fa, ndr, se, tc, ge);
    check_int("rst_fresh_pass_done", dc, 701);
    check_int("rst_fresh_pass_seq", se + (ndr - GROUPS), 0);

    // RD_LAT=3 instance.
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    sel  = 1'b1;
    step();
    run_pass(3, -1, 0, -1, -1, 800, dc, na, nd, fa, ndr, se, tc, ge);
    check_int("rd3_first_acc_en", fa, 4);
    check_int("rd3_done_cycle", dc, GROUPS * (INNEURON + 3 + NDRAIN) + 1);
    check_int("rd3_acc_en_count", na, INNEURON * GROUPS);
    check_int("rd3_drains", ndr, GROUPS);
    check_int("rd3_sequence_errs", se, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
